// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding, nibble width and step-count helper
package nibble_serial_adder_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic int num_steps(input int width);
    return width / NIBBLE_W;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_csa.sv
// Carry_skip_adder: 4-bit ripple adder whose carry-out bypasses the chain when all bits propagate
module Carry_skip_adder (
  output logic [3:0] sum,
  output logic       carry,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);
  logic [3:0] p, g;
  logic [4:0] c;
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = cin;
    for (int i = 0; i < 4; i++) c[i+1] = g[i] | (p[i] & c[i]);
    sum = p ^ c[3:0];
    carry = &p ? cin : c[4];
  end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder sequenced one nibble per clock through a single carry-skip cell
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int K  = num_steps(WIDTH);
  localparam int IW = K > 1 ? $clog2(K) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic c_q, c_d, carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic [NIBBLE_W-1:0] cell_sum;
  logic cell_co, accept;
  Carry_skip_adder u_cell (
    .sum   (cell_sum),
    .carry (cell_co),
    .a     (a_q[NIBBLE_W-1:0]),
    .b     (b_q[NIBBLE_W-1:0]),
    .cin   (c_q)
  );
  // DONE accepts a new start directly so back-to-back issue runs every K+1 cycles
  always_comb begin
    accept = start && (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    acc_d = acc_q;
    sum_d = sum_q;
    carry_d = carry_q;
    done_d = 1'b0;
    if (accept) begin
      a_d = a;
      b_d = b;
      c_d = cin;
      idx_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      acc_d = (acc_q >> NIBBLE_W) | (WIDTH'(cell_sum) << (WIDTH - NIBBLE_W));
      a_d = a_q >> NIBBLE_W;
      b_d = b_q >> NIBBLE_W;
      c_d = cell_co;
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(K - 1)) begin
        state_d = DONE;
        done_d = 1'b1;
        sum_d = acc_d;
        carry_d = cell_co;
      end
    end else begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      acc_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum = sum_q;
  assign carry = carry_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vector table plus hand sequences for WIDTH=16 and WIDTH=4 instances
module tb_nibble_serial_adder;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start16 = 1'b0, cin16 = 1'b0, busy16, done16, carry16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic start4 = 1'b0, cin4 = 1'b0, busy4, done4, carry4;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  int nvec = 0, nerr = 0;
  vec_t v16[9];
  vec_t v4[4];
  always #5 clk = ~clk;
  nibble_serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16)
  );
  nibble_serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic run(input bit w4, input vec_t v);
    int lat;
    @(negedge clk);
    if (w4) begin
      a4 = v.a[3:0]; b4 = v.b[3:0]; cin4 = v.cin; start4 = 1'b1;
    end else begin
      a16 = v.a; b16 = v.b; cin16 = v.cin; start16 = 1'b1;
    end
    @(negedge clk);
    start4 = 1'b0; start16 = 1'b0;
    a16 = ~v.a; b16 = 16'($urandom); cin16 = ~v.cin;
    a4 = ~v.a[3:0]; b4 = 4'($urandom); cin4 = ~v.cin;
    lat = 0;
    while (!(w4 ? done4 : done16) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(w4 ? "latency4" : "latency16", 32'(lat), w4 ? 32'd1 : 32'd4);
    chk(w4 ? "sum4" : "sum16", w4 ? 32'(sum4) : 32'(sum16), w4 ? 32'(v.s[3:0]) : 32'(v.s));
    chk(w4 ? "carry4" : "carry16", 32'(w4 ? carry4 : carry16), 32'(v.c));
    chk(w4 ? "busy_done4" : "busy_done16", 32'(w4 ? busy4 : busy16), 32'd1);
    @(negedge clk);
    chk(w4 ? "done_pulse4" : "done_pulse16", 32'(w4 ? done4 : done16), 32'd0);
    chk(w4 ? "busy_fall4" : "busy_fall16", 32'(w4 ? busy4 : busy16), 32'd0);
  endtask
  initial begin
    int dones, quiet;
    v16[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    v16[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    v16[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    v16[3] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};
    v16[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    v16[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    v16[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    v16[7] = '{16'hFFF0, 16'h000F, 1'b1, 16'h0000, 1'b1};
    v16[8] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};
    v4[0] = '{16'h8, 16'h3, 1'b0, 16'hB, 1'b0};
    v4[1] = '{16'hF, 16'hE, 1'b1, 16'hE, 1'b1};
    v4[2] = '{16'h0, 16'h0, 1'b0, 16'h0, 1'b0};
    v4[3] = '{16'h7, 16'h8, 1'b1, 16'h0, 1'b1};
    #12;
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_sum16", 32'(sum16), 32'd0);
    chk("rst_carry16", 32'(carry16), 32'd0);
    chk("rst_sum4", 32'(sum4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (v16[i]) run(1'b0, v16[i]);
    foreach (v4[i]) run(1'b1, v4[i]);
    // start held high throughout; operands scrambled except when an accept is due
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
    dones = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done16) begin
        dones++;
        chk("lockout_done_cycle", 32'(i), dones == 1 ? 32'd5 : 32'd10);
        chk("lockout_sum", 32'(sum16), dones == 1 ? 32'h3333 : 32'h0003);
      end
      if (i == 5) begin
        a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0;
      end else begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      end
      if (i == 6) chk("lockout_busy_held", 32'(busy16), 32'd1);
      if (i >= 10) start16 = 1'b0;
    end
    chk("lockout_dones", 32'(dones), 32'd2);
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy16), 32'd0);
    chk("midrst_done", 32'(done16), 32'd0);
    chk("midrst_sum", 32'(sum16), 32'd0);
    chk("midrst_carry", 32'(carry16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, v16[3]);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done16 || busy16 || sum16 !== 16'h1001 || carry16 !== 1'b0) quiet++;
    end
    chk("hold_disturbed_cycles", 32'(quiet), 32'd0);
    chk("hold_sum", 32'(sum16), 32'h1001);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
